// File: rtl/sd_cmd_pts.sv
// SD CMD-line parallel-to-serial framer: start, transmit, 38-bit payload, CRC7, end bit.
// Define SD_CMD_PTS_CRC_GEN_EN to build the internal CRC7 generator; otherwise CRC comes in on iCrc7.
module sd_cmd_pts (
  input  logic        iClock_SD,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iLoad_send,
  input  logic [37:0] iCommand,
`ifndef SD_CMD_PTS_CRC_GEN_EN
  input  logic [6:0]  iCrc7,
`endif
  output logic        oCmd_out,
  output logic        oCmd_oe,
  output logic        oTransmission_complete
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StStart   = 3'd1,
    StTxbit   = 3'd2,
    StPayload = 3'd3,
    StCrc     = 3'd4,
    StEnd     = 3'd5,
    StDone    = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [37:0] shreg_q, shreg_d;
  logic [6:0]  crc_q, crc_d;
  logic        load_prev_q, load_prev_d;
  logic        load_rise;
  logic        busy;

`ifdef SD_CMD_PTS_CRC_GEN_EN
  // Serial CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction
`endif

  assign load_rise = iLoad_send & ~load_prev_q;

  always_comb begin
    state_d                = state_q;
    cnt_d                  = cnt_q;
    shreg_d                = shreg_q;
    crc_d                  = crc_q;
    // Outside IDLE the edge detector is held armed-high, so a new frame needs a low seen in IDLE.
    load_prev_d            = 1'b1;
    busy                   = 1'b0;
    oCmd_out               = 1'b1;
    oCmd_oe                = 1'b0;
    oTransmission_complete = 1'b0;

    case (state_q)
      StIdle: begin
        load_prev_d = iLoad_send;
        cnt_d       = 6'd0;
        if (load_rise && iEnable) begin
          state_d = StStart;
          shreg_d = iCommand;
`ifdef SD_CMD_PTS_CRC_GEN_EN
          crc_d   = 7'd0;
`else
          crc_d   = iCrc7;
`endif
        end
      end
      StStart: begin
        busy     = 1'b1;
        oCmd_oe  = 1'b1;
        oCmd_out = 1'b0;
`ifdef SD_CMD_PTS_CRC_GEN_EN
        crc_d    = crc7_step(crc_q, 1'b0);
`endif
        state_d  = StTxbit;
      end
      StTxbit: begin
        busy     = 1'b1;
        oCmd_oe  = 1'b1;
        oCmd_out = 1'b1;
`ifdef SD_CMD_PTS_CRC_GEN_EN
        crc_d    = crc7_step(crc_q, 1'b1);
`endif
        cnt_d    = 6'd0;
        state_d  = StPayload;
      end
      StPayload: begin
        busy     = 1'b1;
        oCmd_oe  = 1'b1;
        oCmd_out = shreg_q[37];
        shreg_d  = {shreg_q[36:0], 1'b0};
`ifdef SD_CMD_PTS_CRC_GEN_EN
        crc_d    = crc7_step(crc_q, shreg_q[37]);
`endif
        if (cnt_q == 6'd37) begin
          cnt_d   = 6'd0;
          state_d = StCrc;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StCrc: begin
        busy     = 1'b1;
        oCmd_oe  = 1'b1;
        oCmd_out = crc_q[6];
        crc_d    = {crc_q[5:0], 1'b0};
        if (cnt_q == 6'd6) begin
          cnt_d   = 6'd0;
          state_d = StEnd;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StEnd: begin
        busy     = 1'b1;
        oCmd_oe  = 1'b1;
        oCmd_out = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        oTransmission_complete = 1'b1;
        state_d                = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 6'd0;
      end
    endcase

    // Losing enable mid-frame drops the frame without a completion pulse.
    if (busy && !iEnable) begin
      state_d = StIdle;
      cnt_d   = 6'd0;
    end
  end

  always_ff @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      state_q     <= StIdle;
      cnt_q       <= 6'd0;
      shreg_q     <= 38'd0;
      crc_q       <= 7'd0;
      load_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      crc_q       <= crc_d;
      load_prev_q <= load_prev_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_pts.sv
// Directed self-checking bench for sd_cmd_pts; expected frames are hand-computed constants.
module tb_sd_cmd_pts;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [37:0] cmd;
  logic [6:0]  crc7;
  logic        cmd_out;
  logic        cmd_oe;
  logic        done;

  int passed = 0;
  int total  = 0;

  sd_cmd_pts u_dut (
    .iClock_SD              (clk),
    .iReset                 (rst_n),
    .iEnable                (en),
    .iLoad_send             (load),
    .iCommand               (cmd),
`ifndef SD_CMD_PTS_CRC_GEN_EN
    .iCrc7                  (crc7),
`endif
    .oCmd_out               (cmd_out),
    .oCmd_oe                (cmd_oe),
    .oTransmission_complete (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drop load for one IDLE cycle, then raise it; returns just after the capture edge (cycle 1).
  task automatic start(input logic [37:0] c, input logic [6:0] crc);
    load = 1'b0;
    tick();
    cmd  = c;
    crc7 = crc;
    load = 1'b1;
    tick();
  endtask

  // Checks cycles 1..49 of a frame; abort_at>0 drops enable during that cycle instead.
  task automatic run_frame(input logic [47:0] f, input string tag, input int abort_at,
                           input int chg_at, input logic [37:0] chg_val);
    int idle_bad;
    for (int c = 1; c <= 48; c++) begin
      check($sformatf("%s bit%0d", tag, c), {63'd0, cmd_out}, {63'd0, f[48-c]});
      if (c == 1 || c == 48 || c == abort_at)
        check($sformatf("%s oe%0d", tag, c), {63'd0, cmd_oe}, 64'd1);
      if (c == chg_at) cmd = chg_val;
      if (c == abort_at) begin
        en = 1'b0;
        tick();
        check({tag, " abort oe"}, {63'd0, cmd_oe}, 64'd0);
        check({tag, " abort out"}, {63'd0, cmd_out}, 64'd1);
        idle_bad = 0;
        for (int k = 0; k < 35; k++) begin
          if (done || cmd_oe || !cmd_out) idle_bad++;
          tick();
        end
        check({tag, " abort quiet"}, 64'(idle_bad), 64'd0);
        return;
      end
      tick();
    end
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " done oe"}, {63'd0, cmd_oe}, 64'd0);
    check({tag, " done out"}, {63'd0, cmd_out}, 64'd1);
    tick();
    check({tag, " done drop"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    cmd   = 38'd0;
    crc7  = 7'd0;

    #2;
    check("rst out", {63'd0, cmd_out}, 64'd1);
    check("rst oe", {63'd0, cmd_oe}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    tick();
    tick();
    check("rst clocked oe", {63'd0, cmd_oe}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Rising load without enable must not start a frame.
    load = 1'b1;
    tick();
    check("noen oe", {63'd0, cmd_oe}, 64'd0);
    tick();
    check("noen oe2", {63'd0, cmd_oe}, 64'd0);
    en = 1'b1;

    // CMD0: 0x40_00000000_95
    start(38'd0, 7'h4A);
    run_frame(48'h40_0000_0000_95, "cmd0", 0, 0, 38'd0);

    // CMD17 arg 0: 0x51_00000000_55
    start({6'd17, 32'h0}, 7'h2A);
    run_frame(48'h51_0000_0000_55, "cmd17", 0, 0, 38'd0);

    // CMD8 arg 0x1AA: 0x48_000001AA_87; command bus scrambled at cycle 10, load held high.
    start({6'd8, 32'h1AA}, 7'h43);
    run_frame(48'h48_0000_01AA_87, "cmd8", 0, 10, '1);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      if (done || cmd_oe) bad++;
      tick();
    end
    check("no retrigger", 64'(bad), 64'd0);

    // Abort by dropping enable in cycle 20, then a full frame.
    start(38'd0, 7'h4A);
    run_frame(48'h40_0000_0000_95, "abort", 20, 0, 38'd0);
    en = 1'b1;
    start(38'd0, 7'h4A);
    run_frame(48'h40_0000_0000_95, "post abort", 0, 0, 38'd0);

    // Reset between edges in cycle 30 with load held high across release.
    start({6'd17, 32'h0}, 7'h2A);
    repeat (29) tick();
    check("pre-reset oe", {63'd0, cmd_oe}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst oe", {63'd0, cmd_oe}, 64'd0);
    check("mid rst out", {63'd0, cmd_out}, 64'd1);
    check("mid rst done", {63'd0, done}, 64'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (cmd_oe || done) bad++;
    end
    check("post rst quiet", 64'(bad), 64'd0);
    start({6'd17, 32'h0}, 7'h2A);
    run_frame(48'h51_0000_0000_55, "post rst", 0, 0, 38'd0);

`ifndef SD_CMD_PTS_CRC_GEN_EN
    // External CRC field 1010101 followed by end bit.
    start(38'd0, 7'h55);
    run_frame(48'h40_0000_0000_AB, "ext crc", 0, 0, 38'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sd_cmd_pts.md
SD_CMD_PTS -- requirements
Module: sd_cmd_pts

Interface
REQ-001 The block SHALL have a single clock; the reset SHALL be asynchronous and active-low.
REQ-002 iClock_SD  input  1  SD card clock; all state SHALL change on its rising edge.
REQ-003 iReset  input  1  asynchronous active-low reset; driven by the physical control block's wrapper-reset output (0 = reset).
REQ-004 iEnable  input  1  parallel-to-serial enable, from the control block's PTS-enable output.
REQ-005 iLoad_send  input  1  load-and-send request, from the control block's load/send output; level signal.
REQ-006 iCommand  input  38  command payload {index[5:0], argument[31:0]}; bit 37 SHALL be sent first.
REQ-007 oCmd_out  output  1  serial CMD line data.
REQ-008 oCmd_oe  output  1  CMD pad output enable (1 = block drives the line).
REQ-009 oTransmission_complete  output  1  one-cycle pulse at the end of a frame; feeds the control block's transmission-complete input.

Function
REQ-010 The block SHALL have states IDLE, START, TXBIT, PAYLOAD, CRC, END and DONE, with a 6-bit bit counter.
REQ-011 In IDLE, a rising edge of iLoad_send while iEnable=1 SHALL capture iCommand into a 38-bit shift register and go to START.
  - Rising edge means iLoad_send=1 now and 0 on the previous cycle.
  - iLoad_send held high SHALL NOT retrigger.
REQ-012 Frame order SHALL be:
  - START: 0, 1 cycle.
  - TXBIT: 1, 1 cycle.
  - PAYLOAD: 38 cycles, MSB first.
  - CRC: 7 cycles, MSB first.
  - END: 1, 1 cycle.
  - Total: 48 cycles.
REQ-013 Latency SHALL be as follows, with capture edge = cycle 0:
  - Frame bits appear on oCmd_out during cycles 1..48.
  - oCmd_oe SHALL be 1 exactly during cycles 1..48.
  - oTransmission_complete SHALL be 1 during cycle 49 only (DONE).
  - The block SHALL then return to IDLE.
REQ-014 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed serially over the 40 bits of START, TXBIT and PAYLOAD.
REQ-015 The CRC register SHALL clear on every capture.
REQ-016 When not driving (oCmd_oe=0), oCmd_out SHALL be 1 (idle-high line).
REQ-017 If iEnable deasserts in any state other than IDLE/DONE, the block SHALL abort:
  - Go to IDLE on the next edge.
  - oCmd_oe=0 and oCmd_out=1 from that edge.
  - No oTransmission_complete pulse.
REQ-018 If iCommand changes during a frame, the frame SHALL be unaffected; only the captured copy is used.
REQ-019 A rising edge of iLoad_send during a frame or in DONE SHALL be ignored.
  - A new frame SHALL require iLoad_send to be seen low while in IDLE and then rise.
REQ-020 Unreachable state encodings SHALL recover to IDLE on the next edge with outputs at idle values.

Reset
REQ-021 While iReset=0, the outputs SHALL be held, independent of the clock, at:
  - oCmd_out=1
  - oCmd_oe=0
  - oTransmission_complete=0
REQ-022 While iReset=0, the internal state SHALL be held, independent of the clock, at:
  - state=IDLE
  - counter=0
  - CRC=0
  - shift register=0
  - previous-iLoad_send register=1, so a level already high at reset release SHALL NOT start a frame.
REQ-023 Reset asserted mid-frame SHALL immediately release the pad (oCmd_oe=0) and discard the frame.

Configuration
REQ-024 The macro SD_CMD_PTS_CRC_GEN_EN SHALL select where the CRC field comes from.
  - Defined: the internal CRC7 generator per REQ-014/015 SHALL be compiled in.
  - Not defined: the generator SHALL be omitted, and an extra input iCrc7[6:0] SHALL exist. It SHALL be captured with iCommand and transmitted MSB first in the CRC field.
  - All other timing SHALL be identical in both builds.

Verification
REQ-025 CMD0 frame: iCommand=38'h0 with iEnable=1, iLoad_send rising -> cycles 1..48 serialize 0x40_00000000_95 MSB first; pulse in cycle 49.
REQ-026 CMD17 frame: iCommand={6'd17,32'h0} -> serialized frame 0x51_00000000_55 (CRC 7'h2A); oCmd_oe high exactly 48 cycles.
REQ-027 Abort on enable: iEnable dropped at cycle 20 -> oCmd_oe=0 and oCmd_out=1 from cycle 21; no complete pulse; next rising iLoad_send sends a full frame.
REQ-028 Reset mid-frame: iReset=0 at cycle 30, between edges -> oCmd_oe=0 immediately; iLoad_send held high through reset release -> no frame until it toggles low then high.
REQ-029 No retrigger: iLoad_send held high for 100 cycles -> exactly one frame and one pulse; iCommand changed at cycle 10 -> frame carries the originally captured value.
REQ-030 Build without SD_CMD_PTS_CRC_GEN_EN: iCommand=38'h0, iCrc7=7'h55 -> CRC field 1010101, end bit 1, pulse in cycle 49.
